// File: rtl/frame_bank_scheduler_pkg.sv
// frame_sched_pkg: shared types, default sizes and helpers for the frame bank scheduler.
//   state_t          capture FSM states
//   *_DEF            default frame size, bank address width and counter width
//   sat_inc          saturating increment, evaluated at 32 bits
package frame_sched_pkg;

    typedef enum logic [1:0] {IDLE, SYNC, CAPTURE, COMMIT} state_t;

    localparam int FRAME_PIXELS_DEF = 76800;
    localparam int ADDR_W_DEF       = 17;
    localparam int CNT_W_DEF        = 8;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
        return (v >= max) ? max : v + 32'd1;
    endfunction

endpackage

// File: rtl/frame_bank_scheduler_mux.sv
// frame_bank_mux: steers capture writes to the write bank and reader accesses to the other bank.
//   cam_pclk, nreset             clock, async active-low reset
//   wr_bank                      bank currently receiving capture writes (read bank is the other)
//   cap_active                   scheduler is in CAPTURE
//   cap_wr_en/addr/data          capture write port
//   rd_addr, rd_gnt              reader address and accepted request
//   bank{0,1}_addr/we/wdata      bank ports
//   bank{0,1}_rdata              bank read data, one cycle after addr
//   rd_valid, rd_data            read response, one cycle after rd_gnt
module frame_bank_mux
    import frame_sched_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              cam_pclk,
    input  logic              nreset,
    input  logic              wr_bank,
    input  logic              cap_active,
    input  logic              cap_wr_en,
    input  logic [ADDR_W-1:0] cap_wr_addr,
    input  logic              cap_wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_gnt,
    input  logic              bank0_rdata,
    input  logic              bank1_rdata,
    output logic [ADDR_W-1:0] bank0_addr,
    output logic              bank0_we,
    output logic              bank0_wdata,
    output logic [ADDR_W-1:0] bank1_addr,
    output logic              bank1_we,
    output logic              bank1_wdata,
    output logic              rd_valid,
    output logic              rd_data
);

    logic rd_valid_q, rd_valid_d;
    logic rd_sel_q, rd_sel_d;

    always_comb begin
        bank0_we    = cap_wr_en & cap_active & ~wr_bank;
        bank1_we    = cap_wr_en & cap_active & wr_bank;
        bank0_wdata = cap_wr_data;
        bank1_wdata = cap_wr_data;
        bank0_addr  = wr_bank ? rd_addr : cap_wr_addr;
        bank1_addr  = wr_bank ? cap_wr_addr : rd_addr;
        rd_valid_d  = rd_gnt;
        // remember which bank a granted read went to, so a swap in the
        // following cycle cannot redirect the returning data
        rd_sel_d    = rd_gnt ? ~wr_bank : rd_sel_q;
    end

    always_ff @(posedge cam_pclk or negedge nreset) begin
        if (!nreset) begin
            rd_valid_q <= 1'b0;
            rd_sel_q   <= 1'b1;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_sel_q   <= rd_sel_d;
        end
    end

    // the bank's own output register is the data stage; gating with valid
    // keeps rd_data at 0 outside a response
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_valid_q & (rd_sel_q ? bank1_rdata : bank0_rdata);

endmodule

// File: rtl/frame_bank_scheduler.sv
// frame_bank_scheduler: ping-pong bitmap bank controller for single-shot / continuous capture.
//   cam_pclk, nreset                           clock, async active-low reset
//   arm, continuous, abort                     capture control
//   cap_in_frame, cap_frame_done, cap_wr_*     capture block interface
//   rd_req, rd_addr, rd_release                reader interface; rd_gnt, rd_valid, rd_data responses
//   frame_ready, busy, frame_count, drop_count status
//   bank{0,1}_addr/we/wdata/rdata              bank ports
//   short_count                                only with FRAME_SCHED_LENGTH_CHECK_EN defined:
//                                              frames dropped for wrong pixel count
module frame_bank_scheduler
    import frame_sched_pkg::*;
#(
    parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic              cam_pclk,
    input  logic              nreset,
    input  logic              arm,
    input  logic              continuous,
    input  logic              abort,
    input  logic              cap_in_frame,
    input  logic              cap_frame_done,
    input  logic              cap_wr_en,
    input  logic [ADDR_W-1:0] cap_wr_addr,
    input  logic              cap_wr_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_release,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic              rd_data,
    output logic              frame_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_count,
    output logic [CNT_W-1:0]  drop_count,
`ifdef FRAME_SCHED_LENGTH_CHECK_EN
    output logic [CNT_W-1:0]  short_count,
`endif
    output logic [ADDR_W-1:0] bank0_addr,
    output logic              bank0_we,
    output logic              bank0_wdata,
    output logic [ADDR_W-1:0] bank1_addr,
    output logic              bank1_we,
    output logic              bank1_wdata,
    input  logic              bank0_rdata,
    input  logic              bank1_rdata
);

    // one past a full frame so overlong frames remain distinguishable
    localparam int          PIX_W   = $clog2(FRAME_PIXELS + 2);
    localparam logic [31:0] PIX_MAX = 32'(FRAME_PIXELS + 1);
    localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});

    state_t             state_q, state_d;
    logic               wr_bank_q, wr_bank_d;
    logic               frame_ready_q, frame_ready_d;
    logic               in_frame_q, in_frame_d;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic [CNT_W-1:0]   frame_count_q, frame_count_d;
    logic [CNT_W-1:0]   drop_count_q, drop_count_d;
    logic               ready_after_rel;
    logic               len_ok;
`ifdef FRAME_SCHED_LENGTH_CHECK_EN
    logic [CNT_W-1:0]   short_count_q, short_count_d;
`endif

    always_comb begin
        state_d         = state_q;
        wr_bank_d       = wr_bank_q;
        in_frame_d      = cap_in_frame;
        pix_d           = pix_q;
        frame_count_d   = frame_count_q;
        drop_count_d    = drop_count_q;
`ifdef FRAME_SCHED_LENGTH_CHECK_EN
        short_count_d   = short_count_q;
        len_ok          = (32'(pix_q) == 32'(FRAME_PIXELS));
`else
        len_ok          = 1'b1;
`endif
        // a release in the commit cycle is honoured before the publish decision
        ready_after_rel = frame_ready_q & ~rd_release;
        frame_ready_d   = ready_after_rel;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = arm ? SYNC : IDLE;
                SYNC: begin
                    if (cap_in_frame & ~in_frame_q) begin
                        state_d = CAPTURE;
                        pix_d   = '0;
                    end
                end
                CAPTURE: begin
                    pix_d   = cap_wr_en ? PIX_W'(sat_inc(32'(pix_q), PIX_MAX)) : pix_q;
                    state_d = cap_frame_done ? COMMIT : CAPTURE;
                end
                COMMIT: begin
                    state_d = continuous ? SYNC : IDLE;
                    if (len_ok & ~ready_after_rel) begin
                        wr_bank_d     = ~wr_bank_q;
                        frame_ready_d = 1'b1;
                        frame_count_d = CNT_W'(sat_inc(32'(frame_count_q), CNT_MAX));
                    end else begin
                        drop_count_d  = CNT_W'(sat_inc(32'(drop_count_q), CNT_MAX));
`ifdef FRAME_SCHED_LENGTH_CHECK_EN
                        short_count_d = len_ok ? short_count_q : CNT_W'(sat_inc(32'(short_count_q), CNT_MAX));
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge cam_pclk or negedge nreset) begin
        if (!nreset) begin
            state_q       <= IDLE;
            wr_bank_q     <= 1'b0;
            frame_ready_q <= 1'b0;
            in_frame_q    <= 1'b0;
            pix_q         <= '0;
            frame_count_q <= '0;
            drop_count_q  <= '0;
`ifdef FRAME_SCHED_LENGTH_CHECK_EN
            short_count_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            wr_bank_q     <= wr_bank_d;
            frame_ready_q <= frame_ready_d;
            in_frame_q    <= in_frame_d;
            pix_q         <= pix_d;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
`ifdef FRAME_SCHED_LENGTH_CHECK_EN
            short_count_q <= short_count_d;
`endif
        end
    end

    assign rd_gnt      = rd_req & frame_ready_q & ~rd_release;
    assign frame_ready = frame_ready_q;
    assign busy        = (state_q != IDLE);
    assign frame_count = frame_count_q;
    assign drop_count  = drop_count_q;
`ifdef FRAME_SCHED_LENGTH_CHECK_EN
    assign short_count = short_count_q;
`endif

    frame_bank_mux #(.ADDR_W(ADDR_W)) u_mux (
        .cam_pclk    (cam_pclk),
        .nreset      (nreset),
        .wr_bank     (wr_bank_q),
        .cap_active  (state_q == CAPTURE),
        .cap_wr_en   (cap_wr_en),
        .cap_wr_addr (cap_wr_addr),
        .cap_wr_data (cap_wr_data),
        .rd_addr     (rd_addr),
        .rd_gnt      (rd_gnt),
        .bank0_rdata (bank0_rdata),
        .bank1_rdata (bank1_rdata),
        .bank0_addr  (bank0_addr),
        .bank0_we    (bank0_we),
        .bank0_wdata (bank0_wdata),
        .bank1_addr  (bank1_addr),
        .bank1_we    (bank1_we),
        .bank1_wdata (bank1_wdata),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data)
    );

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// tb_frame_bank_scheduler: directed and randomized checks of frame_bank_scheduler against a frame-level model.
module tb_frame_bank_scheduler;

    localparam int FP = 64;
    localparam int AW = 17;
    localparam int CW = 8;

    logic          cam_pclk = 1'b0;
    logic          nreset;
    logic          arm, continuous, abort, cap_in_frame, cap_frame_done, cap_wr_en, cap_wr_data;
    logic [AW-1:0] cap_wr_addr, rd_addr;
    logic          rd_req, rd_release;
    logic          rd_gnt, rd_valid, rd_data, frame_ready, busy;
    logic [CW-1:0] frame_count, drop_count;
    logic [AW-1:0] bank0_addr, bank1_addr;
    logic          bank0_we, bank0_wdata, bank1_we, bank1_wdata;
    logic          bank0_rdata, bank1_rdata;
`ifdef FRAME_SCHED_LENGTH_CHECK_EN
    logic [CW-1:0] short_count;
    localparam bit LEN_CHK = 1'b1;
`else
    localparam bit LEN_CHK = 1'b0;
`endif

    frame_bank_scheduler #(.FRAME_PIXELS(FP), .ADDR_W(AW), .CNT_W(CW)) dut (
        .cam_pclk       (cam_pclk),
        .nreset         (nreset),
        .arm            (arm),
        .continuous     (continuous),
        .abort          (abort),
        .cap_in_frame   (cap_in_frame),
        .cap_frame_done (cap_frame_done),
        .cap_wr_en      (cap_wr_en),
        .cap_wr_addr    (cap_wr_addr),
        .cap_wr_data    (cap_wr_data),
        .rd_req         (rd_req),
        .rd_addr        (rd_addr),
        .rd_release     (rd_release),
        .rd_gnt         (rd_gnt),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .frame_ready    (frame_ready),
        .busy           (busy),
        .frame_count    (frame_count),
        .drop_count     (drop_count),
`ifdef FRAME_SCHED_LENGTH_CHECK_EN
        .short_count    (short_count),
`endif
        .bank0_addr     (bank0_addr),
        .bank0_we       (bank0_we),
        .bank0_wdata    (bank0_wdata),
        .bank1_addr     (bank1_addr),
        .bank1_we       (bank1_we),
        .bank1_wdata    (bank1_wdata),
        .bank0_rdata    (bank0_rdata),
        .bank1_rdata    (bank1_rdata)
    );

    always #5 cam_pclk = ~cam_pclk;

    // bank memories: synchronous write, registered read
    logic mem0 [0:(1<<AW)-1];
    logic mem1 [0:(1<<AW)-1];
    always @(posedge cam_pclk) begin
        if (bank0_we) mem0[bank0_addr] <= bank0_wdata;
        if (bank1_we) mem1[bank1_addr] <= bank1_wdata;
        bank0_rdata <= mem0[bank0_addr];
        bank1_rdata <= mem1[bank1_addr];
    end

    int checks = 0;
    int errors = 0;

    // frame-level reference model
    int   m_wr, m_ready, m_fc, m_dc, m_sc;
    bit   m_armed;
    logic ref_bank [0:1][0:FP];
    logic img [0:FP];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge cam_pclk);
        #1;
    endtask

    function automatic logic we_of(input int b);
        return (b != 0) ? bank1_we : bank0_we;
    endfunction

    function automatic logic [AW-1:0] addr_of(input int b);
        return (b != 0) ? bank1_addr : bank0_addr;
    endfunction

    function automatic logic mem_of(input int b, input int a);
        return (b != 0) ? mem1[a] : mem0[a];
    endfunction

    task automatic do_reset();
        nreset = 1'b0;
        {arm, continuous, abort, cap_in_frame, cap_frame_done, cap_wr_en, cap_wr_data, rd_req, rd_release} = '0;
        cap_wr_addr = '0;
        rd_addr = '0;
        #3;
        step();
        nreset = 1'b1;
        step();
        m_wr = 0; m_ready = 0; m_fc = 0; m_dc = 0; m_sc = 0; m_armed = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
        if (!m_armed) m_armed = 1'b1;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
        m_armed = 1'b0;
    endtask

    task automatic status_chk(input string tag);
        chk({tag, "_ready"}, 32'(frame_ready), 32'(m_ready));
        chk({tag, "_fcount"}, 32'(frame_count), 32'(m_fc));
        chk({tag, "_dcount"}, 32'(drop_count), 32'(m_dc));
        chk({tag, "_busy"}, 32'(busy), 32'(m_armed));
`ifdef FRAME_SCHED_LENGTH_CHECK_EN
        chk({tag, "_scount"}, 32'(short_count), 32'(m_sc));
`endif
        rd_addr = 17'h1234;
        cap_wr_addr = 17'h0abc;
        #1;
        chk({tag, "_rdbank_addr"}, 32'(addr_of(1 - m_wr)), 32'h1234);
        chk({tag, "_wrbank_addr"}, 32'(addr_of(m_wr)), 32'h0abc);
    endtask

    task automatic read_chk(input string tag, input int a);
        bit g;
        g = (m_ready != 0);
        rd_addr = AW'(a);
        rd_req = 1'b1;
        #1;
        chk({tag, "_gnt"}, 32'(rd_gnt), 32'(g));
        step();
        rd_req = 1'b0;
        chk({tag, "_valid"}, 32'(rd_valid), 32'(g));
        if (g) chk({tag, "_data"}, 32'(rd_data), 32'(ref_bank[1 - m_wr][a]));
    endtask

    task automatic bank_chk(input string tag, input int b, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) if (mem_of(b, i) !== ref_bank[b][i]) bad++;
        chk(tag, 32'(bad), 32'd0);
    endtask

    task automatic drive_frame(input int n, input bit rel);
        bit capt;
        bit ok;
        capt = m_armed;
        cap_in_frame = 1'b0;
        step();
        cap_in_frame = 1'b1;
        step();
        for (int i = 0; i < n; i++) begin
            cap_wr_en = 1'b1;
            cap_wr_addr = AW'(i);
            cap_wr_data = 1'($urandom);
            img[i] = cap_wr_data;
            if (i == 0) begin
                #1;
                chk("we_wrbank", 32'(we_of(m_wr)), 32'(capt));
                chk("we_rdbank", 32'(we_of(1 - m_wr)), 32'd0);
            end
            step();
        end
        cap_wr_en = 1'b0;
        cap_frame_done = 1'b1;
        rd_release = rel;
        step();
        cap_frame_done = 1'b0;
        rd_release = 1'b0;
        cap_in_frame = 1'b0;
        step();
        if (rel) m_ready = 0;
        if (capt) begin
            for (int i = 0; i < n; i++) ref_bank[m_wr][i] = img[i];
            ok = !LEN_CHK || (n == FP);
            if (!ok) begin
                m_dc++;
                m_sc++;
            end else if (m_ready != 0) begin
                m_dc++;
            end else begin
                m_wr = 1 - m_wr;
                m_ready = 1;
                m_fc++;
            end
            m_armed = continuous;
        end
    endtask

    initial begin
        // reset values
        nreset = 1'b0;
        {arm, continuous, abort, cap_in_frame, cap_frame_done, cap_wr_en, cap_wr_data, rd_req, rd_release} = '0;
        cap_wr_addr = 17'h00111;
        rd_addr = 17'h00222;
        #12;
        chk("rst_ready", 32'(frame_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fcount", 32'(frame_count), 0);
        chk("rst_dcount", 32'(drop_count), 0);
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_data", 32'(rd_data), 0);
        chk("rst_we", 32'({bank0_we, bank1_we}), 0);
        chk("rst_bank0_addr", 32'(bank0_addr), 32'h00111);
        chk("rst_bank1_addr", 32'(bank1_addr), 32'h00222);
        do_reset();

        // single shot
        continuous = 1'b0;
        do_arm();
        chk("ss_busy_sync", 32'(busy), 1);
        drive_frame(FP, 1'b0);
        status_chk("ss");
        read_chk("ss_rd5", 5);
        for (int k = 0; k < 3; k++) read_chk("ss_rdr", $urandom_range(0, FP - 1));

        // continuous, never released
        do_reset();
        continuous = 1'b1;
        do_arm();
        for (int f = 0; f < 3; f++) drive_frame(FP, 1'b0);
        status_chk("cont");
        bank_chk("cont_bank0", 0, FP);
        bank_chk("cont_bank1", 1, FP);
        do_abort();

        // release coincident with frame done
        do_reset();
        continuous = 1'b1;
        do_arm();
        drive_frame(FP, 1'b0);
        drive_frame(FP, 1'b1);
        status_chk("relc");
        read_chk("relc_rd", $urandom_range(0, FP - 1));
        do_abort();

        // arm while a frame is already in progress
        do_reset();
        continuous = 1'b0;
        cap_in_frame = 1'b1;
        step();
        do_arm();
        for (int i = 0; i < 10; i++) begin
            cap_wr_en = 1'b1;
            cap_wr_addr = AW'(i);
            cap_wr_data = 1'b1;
            #1;
            if (i == 0) chk("mid_no_we", 32'({bank0_we, bank1_we}), 0);
            step();
        end
        cap_wr_en = 1'b0;
        cap_frame_done = 1'b1;
        step();
        cap_frame_done = 1'b0;
        cap_in_frame = 1'b0;
        step();
        status_chk("mid_skip");
        drive_frame(FP, 1'b0);
        status_chk("mid_next");

        // abort during capture
        do_reset();
        continuous = 1'b0;
        do_arm();
        drive_frame(FP, 1'b0);
        do_arm();
        cap_in_frame = 1'b0;
        step();
        cap_in_frame = 1'b1;
        step();
        for (int i = 0; i <= 30; i++) begin
            cap_wr_en = 1'b1;
            cap_wr_addr = AW'(i);
            cap_wr_data = 1'($urandom);
            ref_bank[m_wr][i] = cap_wr_data;
            if (i == 30) abort = 1'b1;
            step();
        end
        abort = 1'b0;
        m_armed = 1'b0;
        chk("abort_we_after", 32'({bank0_we, bank1_we}), 0);
        cap_wr_en = 1'b0;
        cap_in_frame = 1'b0;
        status_chk("abort");
        read_chk("abort_rd", $urandom_range(0, FP - 1));

`ifdef FRAME_SCHED_LENGTH_CHECK_EN
        // short frame takes the drop path
        do_reset();
        continuous = 1'b0;
        do_arm();
        drive_frame(FP - 1, 1'b0);
        status_chk("short");
`endif

        // randomized continuous run
        do_reset();
        continuous = 1'b1;
        do_arm();
        for (int it = 0; it < 16; it++) begin
            int n;
            n = (LEN_CHK && ($urandom_range(0, 3) == 0)) ? FP - 1 : FP;
            drive_frame(n, 1'($urandom_range(0, 1)));
            status_chk("rnd");
            read_chk("rnd_rd", $urandom_range(0, FP - 1));
            if ($urandom_range(0, 2) == 0) begin
                rd_release = 1'b1;
                step();
                rd_release = 1'b0;
                m_ready = 0;
            end
        end
        do_abort();
        status_chk("rnd_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
